// File: rtl/jt900h_ramprefetch.sv
// rtl/jt900h_ramprefetch.sv - circular 16-bit RAM prefetch window serving unaligned OUTW-bit reads
// Optional invalidate input enabled by defining JT900H_RAMPF_INV_EN.
module jt900h_ramprefetch #(
    parameter int AW    = 24,
    parameter int DEPTH = 8,
    parameter int OUTW  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
`ifdef JT900H_RAMPF_INV_EN
    input  logic            inv,
`endif
    input  logic [AW-1:0]   req_addr,
    output logic [OUTW-1:0] dout,
    output logic            ram_rdy,
    output logic [AW-1:0]   ram_addr,
    output logic            ram_cs,
    input  logic [15:0]     ram_dout,
    input  logic            ram_ok
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [AW-2:0] bw;
    logic [IW-1:0] head;
    logic [CW-1:0] cnt;
    logic [15:0]   wbuf [DEPTH];

    logic [AW-2:0] wa, o;
    logic [CW:0]   nw, need;
    logic          in_win, hit, consume, fill, inv_act;
    logic [IW-1:0] idx0, idx1, idx2;
    logic [47:0]   win, win_sh;

`ifdef JT900H_RAMPF_INV_EN
    assign inv_act = inv;
`else
    assign inv_act = 1'b0;
`endif

    assign wa      = req_addr[AW-1:1];
    assign o       = wa - bw;
    assign nw      = (CW+1)'(OUTW/16) + (CW+1)'(req_addr[0]);
    assign in_win  = (o < (AW-1)'(DEPTH));
    assign need    = (CW+1)'(o[IW-1:0]) + nw;
    assign hit     = in_win && (need <= {1'b0, cnt});
    // o == cnt still counts as consume: the word arriving now is the new base word
    assign consume = (o <= (AW-1)'(cnt));

    assign ram_rdy  = hit & cen & ~rst & ~inv_act;
    assign ram_cs   = ~rst & (cnt < CW'(DEPTH));
    assign ram_addr = {bw + (AW-1)'(cnt), 1'b0};
    assign fill     = cen & ram_cs & ram_ok & ~inv_act;

    assign idx0   = head + o[IW-1:0];
    assign idx1   = idx0 + IW'(1);
    assign idx2   = idx0 + IW'(2);
    assign win    = {wbuf[idx2], wbuf[idx1], wbuf[idx0]};
    assign win_sh = req_addr[0] ? {8'd0, win[47:8]} : win;
    assign dout   = ram_rdy ? win_sh[OUTW-1:0] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            bw   <= '0;
            head <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) wbuf[i] <= '0;
        end else if (cen) begin
            bw <= wa;
            if (inv_act || !consume) begin
                cnt <= '0;
            end else begin
                head <= head + o[IW-1:0];
                cnt  <= cnt - o[CW-1:0] + CW'(fill);
                if (fill) wbuf[head + cnt[IW-1:0]] <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_jt900h_ramprefetch.sv
// tb/tb_jt900h_ramprefetch.sv - self-checking bench for jt900h_ramprefetch against a window model
module tb_jt900h_ramprefetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b0;
    logic        inv = 1'b0;
    logic        ram_ok = 1'b0;
    logic [23:0] req_addr = 24'd0;
    logic [31:0] dout;
    logic        ram_rdy;
    logic [23:0] ram_addr;
    logic        ram_cs;
    logic [15:0] ram_dout;

    int n_chk = 0;
    int n_pass = 0;

    logic [22:0] m_bw = 23'd0;
    int          m_cnt = 0;

    logic        last_rdy, last_cs;
    logic [23:0] last_addr;
    logic [31:0] last_dout;
    logic [23:0] addr_hist [64];
    logic        cs_hist [64];

    jt900h_ramprefetch #(.AW(24), .DEPTH(8), .OUTW(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
`ifdef JT900H_RAMPF_INV_EN
        .inv      (inv),
`endif
        .req_addr (req_addr),
        .dout     (dout),
        .ram_rdy  (ram_rdy),
        .ram_addr (ram_addr),
        .ram_cs   (ram_cs),
        .ram_dout (ram_dout),
        .ram_ok   (ram_ok)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mb(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ {a[22:16], a[23]} ^ 8'h5a;
    endfunction

    function automatic logic [31:0] exp_bytes(input logic [23:0] a);
        return {mb(a + 24'd3), mb(a + 24'd2), mb(a + 24'd1), mb(a)};
    endfunction

    always_comb ram_dout = {mb(ram_addr | 24'd1), mb(ram_addr & 24'hfffffe)};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    endtask

    // One clock: compare outputs against the model mid-cycle, then advance the model.
    task automatic cycle();
        logic [22:0] wa, o, nb;
        int          nw, nc, fill;
        logic        e_cs, e_rdy;
        logic [23:0] e_addr;
        @(negedge clk);
        wa     = req_addr[23:1];
        o      = wa - m_bw;
        nw     = 2 + int'(req_addr[0]);
        e_cs   = !rst && (m_cnt < 8);
        e_addr = {m_bw + 23'(m_cnt), 1'b0};
        e_rdy  = !rst && cen && !inv && (o < 23'd8) && (int'(o) + nw <= m_cnt);
        chk("ram_cs", 64'(ram_cs), 64'(e_cs));
        chk("ram_addr", 64'(ram_addr), 64'(e_addr));
        chk("ram_rdy", 64'(ram_rdy), 64'(e_rdy));
        if (e_rdy) chk("dout", 64'(dout), 64'(exp_bytes(req_addr)));
        nb = m_bw;
        nc = m_cnt;
        if (rst) begin
            nb = 23'd0;
            nc = 0;
        end else if (cen) begin
            fill = (e_cs && ram_ok && !inv) ? 1 : 0;
            nb = wa;
            if (!inv && int'(o) <= m_cnt && o < 23'd16) nc = m_cnt - int'(o) + fill;
            else nc = 0;
        end
        last_rdy  = ram_rdy;
        last_cs   = ram_cs;
        last_addr = ram_addr;
        last_dout = dout;
        @(posedge clk);
        m_bw  = nb;
        m_cnt = nc;
        #1;
    endtask

    task automatic do_reset(input logic [23:0] a);
        rst = 1'b1; cen = 1'b1; ram_ok = 1'b1; inv = 1'b0; req_addr = a;
        cycle();
        chk("rst_cs", 64'(last_cs), 64'd0);
        chk("rst_rdy", 64'(last_rdy), 64'd0);
        rst = 1'b0;
    endtask

    task automatic run_until_rdy(output int idx);
        idx = -1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            addr_hist[i] = last_addr;
            if (last_rdy) begin
                idx = i;
                break;
            end
        end
        if (idx < 0) chk("rdy_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int idx, rdys;
        int r;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // reset at 0xcafe, first fetch from 0xcafe, ready after two fills
        do_reset(24'hcafe);
        run_until_rdy(idx);
        chk("cafe_rdy_idx", 64'(idx), 64'd3);
        chk("cafe_first_fetch", 64'(addr_hist[1]), 64'h00cafe);
        chk("cafe_dout", 64'(last_dout), 64'(exp_bytes(24'hcafe)));

        // odd address needs three words
        do_reset(24'h001001);
        run_until_rdy(idx);
        chk("odd_rdy_idx", 64'(idx), 64'd4);
        chk("odd_fetch0", 64'(addr_hist[1]), 64'h001000);
        chk("odd_fetch1", 64'(addr_hist[2]), 64'h001002);
        chk("odd_fetch2", 64'(addr_hist[3]), 64'h001004);
        chk("odd_dout", 64'(last_dout),
            64'({mb(24'h001004), mb(24'h001003), mb(24'h001002), mb(24'h001001)}));

        // hold address until the window is full: ram_cs drops after DEPTH fills
        do_reset(24'h000100);
        for (int i = 0; i < 12; i++) begin
            cycle();
            cs_hist[i] = last_cs;
        end
        chk("full_cs_before", 64'(cs_hist[8]), 64'd1);
        chk("full_cs_drop", 64'(cs_hist[9]), 64'd0);

        // word-stride streaming sustains ram_rdy every cycle
        do_reset(24'h000300);
        run_until_rdy(idx);
        rdys = 0;
        for (int i = 0; i < 40; i++) begin
            if (last_rdy) req_addr = req_addr + 24'd2;
            cycle();
            if (last_rdy) rdys++;
        end
        chk("stride2_sustained", 64'(rdys), 64'd40);
        for (int i = 0; i < 40; i++) begin
            if (last_rdy) req_addr = req_addr + 24'd4;
            cycle();
        end

        // in-window forward jump, then a miss with an in-flight word dropped
        do_reset(24'h000100);
        for (int i = 0; i < 7; i++) cycle();
        ram_ok = 1'b0;
        req_addr = 24'h000106;
        cycle();
        chk("jump_hit", 64'(last_rdy), 64'd1);
        chk("jump_dout", 64'(last_dout), 64'(exp_bytes(24'h000106)));
        cycle();
        chk("jump_hit2", 64'(last_rdy), 64'd1);
        ram_ok = 1'b1;
        req_addr = 24'h000200;
        cycle();
        chk("miss_rdy", 64'(last_rdy), 64'd0);
        cycle();
        chk("miss_refetch", 64'(last_addr), 64'h000200);
        cycle();
        chk("miss_next", 64'(last_addr), 64'h000202);

        // address wrap at the top of memory
        do_reset(24'hfffffe);
        run_until_rdy(idx);
        chk("wrap_rdy_idx", 64'(idx), 64'd3);
        chk("wrap_fetch0", 64'(addr_hist[1]), 64'hfffffe);
        chk("wrap_fetch1", 64'(addr_hist[2]), 64'h000000);
        chk("wrap_dout", 64'(last_dout),
            64'({mb(24'h000001), mb(24'h000000), mb(24'hffffff), mb(24'hfffffe)}));

        // random traffic with cen gaps, ram_ok gaps, resets and jumps
        do_reset(24'h004000);
        for (int i = 0; i < 3000; i++) begin
            cen    = ($urandom % 4) != 0;
            ram_ok = ($urandom % 3) != 0;
            rst    = ($urandom % 200) == 0;
`ifdef JT900H_RAMPF_INV_EN
            inv    = ($urandom % 150) == 0;
`endif
            r = int'($urandom % 16);
            if (last_rdy || ($urandom % 20) == 0) begin
                if (r < 6)       req_addr = req_addr + 24'd2;
                else if (r < 10) req_addr = req_addr + 24'd4;
                else if (r < 12) req_addr = req_addr + 24'd1;
                else if (r == 12) req_addr = req_addr;
                else if (r == 13) req_addr = req_addr + 24'($urandom % 32);
                else if (r == 14) req_addr = req_addr - 24'($urandom % 16);
                else             req_addr = 24'($urandom);
            end
            cycle();
        end
        rst = 1'b0;
        inv = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
